// File: rtl/viterbi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// viterbi_pkg: trellis constants and helpers for the rate-2/3 Viterbi decoder.
// Rev 1.0
// ---------------------------------------------------------------------------
package viterbi_pkg;

  localparam int NUM_STATES  = 4;
  localparam int INIT_PM_DEF = 7;

  // State {a,b} = {X1N_1, X1N_2}
  typedef logic [1:0] state_t;

  function automatic logic expected_y1(input state_t s, input logic u);
    return u ^ s[0];
  endfunction

  function automatic logic expected_y0(input state_t s);
    return s[1];
  endfunction

  function automatic state_t next_state(input state_t s, input logic u);
    return {u, s[1]};
  endfunction

  function automatic state_t pred(input state_t ns, input logic b);
    return {ns[0], b};
  endfunction

  function automatic logic [1:0] branch_metric(input logic y1, input logic y0,
                                               input state_t s, input logic u);
    return {1'b0, y1 ^ expected_y1(s, u)} + {1'b0, y0 ^ expected_y0(s)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_decode_acs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// viterbi_acs: add-compare-select for one next state, saturating add.
// Rev 1.0
// ---------------------------------------------------------------------------
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int PM_W = 4
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [1:0]      bm0_i,
  input  logic [1:0]      bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);

  logic [PM_W:0]   sum0;
  logic [PM_W:0]   sum1;
  logic [PM_W-1:0] cand0;
  logic [PM_W-1:0] cand1;

  always_comb begin
    sum0  = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
    sum1  = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};
    cand0 = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
    cand1 = sum1[PM_W] ? '1 : sum1[PM_W-1:0];
    // Strict compare: a tie keeps the b=0 predecessor
    dec_o = (cand1 < cand0);
    pm_o  = dec_o ? cand1 : cand0;
  end

endmodule
`default_nettype wire

// File: rtl/viterbi_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// viterbi_decode: hard-decision 4-state register-exchange Viterbi decoder.
// Rev 1.0
// ---------------------------------------------------------------------------
module viterbi_decode
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 12,
  parameter int PM_W     = 4,
  parameter int INIT_PM  = INIT_PM_DEF
) (
  input  logic            clk,
  input  logic            res,
  input  logic            sync_clr,
  input  logic            in_valid,
  input  logic            y2_in,
  input  logic            y1_in,
  input  logic            y0_in,
  output logic            out_valid,
  output logic            x2_out,
  output logic            x1_out,
  output logic [PM_W-1:0] best_pm
);

  localparam int FILL_W = $clog2(TB_DEPTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH - 1);

  logic [PM_W-1:0]     pm_q    [NUM_STATES];
  logic [PM_W-1:0]     pm_d    [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_q  [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_d  [NUM_STATES];
  logic [TB_DEPTH-1:0] y2_q, y2_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  state_t              best_q, best_d;
  logic [PM_W-1:0]     best_pm_q, best_pm_d;
  logic                out_valid_q, out_valid_d;

  logic [PM_W-1:0]     cand    [NUM_STATES];
  logic                dec     [NUM_STATES];
  logic [TB_DEPTH-1:0] surv_nx [NUM_STATES];
  logic [PM_W-1:0]     min_pm;
  state_t              best_nx;
  logic [PM_W:0]       acc;

  for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
    localparam state_t NS = state_t'(g);
    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = branch_metric(y1_in, y0_in, pred(NS, 1'b0), NS[1]);
    assign bm1 = branch_metric(y1_in, y0_in, pred(NS, 1'b1), NS[1]);

    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0_i (pm_q[pred(NS, 1'b0)]),
      .pm1_i (pm_q[pred(NS, 1'b1)]),
      .bm0_i (bm0),
      .bm1_i (bm1),
      .pm_o  (cand[g]),
      .dec_o (dec[g])
    );

    assign surv_nx[g] = {surv_q[pred(NS, dec[g])][TB_DEPTH-2:0], NS[1]};
  end

  always_comb begin
    min_pm  = cand[0];
    best_nx = '0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (cand[s] < min_pm) begin
        min_pm  = cand[s];
        best_nx = state_t'(s);
      end
    end
    // best_pm accumulates the per-step normalization offset, i.e. the
    // un-normalized metric of the winning path
    acc = {1'b0, best_pm_q} + {1'b0, min_pm};

    pm_d        = pm_q;
    surv_d      = surv_q;
    y2_d        = y2_q;
    fill_d      = fill_q;
    best_d      = best_q;
    best_pm_d   = best_pm_q;
    out_valid_d = 1'b0;

    if (sync_clr) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_d[s]   = (s == 0) ? '0 : PM_W'(INIT_PM);
        surv_d[s] = '0;
      end
      y2_d      = '0;
      fill_d    = '0;
      best_d    = '0;
      best_pm_d = '0;
    end else if (in_valid) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_d[s]   = cand[s] - min_pm;
        surv_d[s] = surv_nx[s];
      end
      y2_d        = {y2_q[TB_DEPTH-2:0], y2_in};
      fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
      best_d      = best_nx;
      best_pm_d   = acc[PM_W] ? '1 : acc[PM_W-1:0];
      out_valid_d = (fill_q == FILL_MAX);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_W'(INIT_PM);
        surv_q[s] <= '0;
      end
      y2_q        <= '0;
      fill_q      <= '0;
      best_q      <= '0;
      best_pm_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      y2_q        <= y2_d;
      fill_q      <= fill_d;
      best_q      <= best_d;
      best_pm_q   <= best_pm_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Oldest bits are taken from registered state, so outputs hold across gaps
  assign out_valid = out_valid_q;
  assign x2_out    = y2_q[TB_DEPTH-1];
  assign x1_out    = surv_q[best_q][TB_DEPTH-1];
  assign best_pm   = best_pm_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_viterbi_decode: directed self-checking bench for viterbi_decode.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_viterbi_decode;

  localparam int D = 12;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       sync_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       y2_in = 1'b0;
  logic       y1_in = 1'b0;
  logic       y0_in = 1'b0;
  logic       out_valid;
  logic       x2_out;
  logic       x1_out;
  logic [3:0] best_pm;

  int checks   = 0;
  int failures = 0;

  logic [1:0] enc_s;

  bit x1_seq [20] = '{1,0,1,1,0,0,1,0, 0,0,0,0,0,0,0,0,0,0,0,0};
  bit y2_seq [20] = '{1,1,0,0,1,0,1,1, 0,0,0,0,0,0,0,0,0,0,0,0};
  logic [1:0] tie_syms [24] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01,
                                2'b10, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00,
                                2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10,
                                2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01};

  // Reference decoder: un-normalized integer metrics, same tie rules
  int          mpm [4];
  bit [D-1:0]  msv [4];
  bit [D-1:0]  my2;
  int          mfill;

  viterbi_decode #(.TB_DEPTH(D), .PM_W(4), .INIT_PM(7)) dut (
    .clk       (clk),
    .res       (res),
    .sync_clr  (sync_clr),
    .in_valid  (in_valid),
    .y2_in     (y2_in),
    .y1_in     (y1_in),
    .y0_in     (y0_in),
    .out_valid (out_valid),
    .x2_out    (x2_out),
    .x1_out    (x1_out),
    .best_pm   (best_pm)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic c, input logic y2,
                       input logic y1, input logic y0);
    in_valid = v; sync_clr = c; y2_in = y2; y1_in = y1; y0_in = y0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_res;
    in_valid = 1'b0; sync_clr = 1'b0;
    #2 res = 1'b1;
    @(posedge clk);
    #2 res = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic encode(input bit u, output logic y1, output logic y0);
    y1    = u ^ enc_s[0];
    y0    = enc_s[1];
    enc_s = {u, enc_s[1]};
  endtask

  task automatic model_reset;
    mpm = '{0, 7, 7, 7};
    for (int s = 0; s < 4; s++) msv[s] = '0;
    my2   = '0;
    mfill = 0;
  endtask

  task automatic model_step(input bit y2, input bit y1, input bit y0,
                            output bit ev, output bit ex2, output bit ex1,
                            output int ebest);
    int         npm [4];
    bit [D-1:0] nsv [4];
    int         c0, c1, u, a, mn, bs;
    for (int ns = 0; ns < 4; ns++) begin
      u  = ns / 2;
      a  = ns % 2;
      c0 = mpm[2*a]   + int'(y1 != bit'(u))     + int'(y0 != bit'(a));
      c1 = mpm[2*a+1] + int'(y1 != bit'(u ^ 1)) + int'(y0 != bit'(a));
      if (c1 < c0) begin
        npm[ns] = c1; nsv[ns] = {msv[2*a+1][D-2:0], bit'(u)};
      end else begin
        npm[ns] = c0; nsv[ns] = {msv[2*a][D-2:0], bit'(u)};
      end
    end
    mn = npm[0]; bs = 0;
    for (int s = 1; s < 4; s++) if (npm[s] < mn) begin mn = npm[s]; bs = s; end
    mpm = npm;
    msv = nsv;
    my2 = {my2[D-2:0], y2};
    ev  = (mfill == D - 1);
    if (mfill < D - 1) mfill++;
    ex1   = msv[bs][D-1];
    ex2   = my2[D-1];
    ebest = (mn > 15) ? 15 : mn;
  endtask

  task automatic test_reset;
    res = 1'b1;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (x1_out !== 1'b0) begin failures++; $display("FAIL reset_x1: got %b want 0", x1_out); end
    checks++; if (x2_out !== 1'b0) begin failures++; $display("FAIL reset_x2: got %b want 0", x2_out); end
    checks++; if (best_pm !== 4'd0) begin failures++; $display("FAIL reset_best_pm: got %0d want 0", best_pm); end
    @(posedge clk);
    #2 res = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_error_free(input bit gaps);
    logic y1, y0;
    enc_s = 2'b00;
    for (int k = 0; k < 20; k++) begin
      encode(x1_seq[k], y1, y0);
      drive(1'b1, 1'b0, y2_seq[k], y1, y0);
      if (k < D - 1) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ef_early_valid step %0d: got %b want 0", k, out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ef_valid step %0d: got %b want 1", k, out_valid); end
        checks++; if (x1_out !== x1_seq[k-D+1]) begin failures++; $display("FAIL ef_x1 step %0d: got %b want %b", k, x1_out, x1_seq[k-D+1]); end
        checks++; if (x2_out !== y2_seq[k-D+1]) begin failures++; $display("FAIL ef_x2 step %0d: got %b want %b", k, x2_out, y2_seq[k-D+1]); end
      end
      checks++; if (best_pm !== 4'd0) begin failures++; $display("FAIL ef_best_pm step %0d: got %0d want 0", k, best_pm); end
      if (gaps) begin
        drive(1'b0, 1'b0, ~y2_seq[k], ~y1, ~y0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_valid step %0d: got %b want 0", k, out_valid); end
        checks++; if (best_pm !== 4'd0) begin failures++; $display("FAIL gap_best_pm step %0d: got %0d want 0", k, best_pm); end
        if (k >= D - 1) begin
          checks++; if (x1_out !== x1_seq[k-D+1]) begin failures++; $display("FAIL gap_x1_hold step %0d: got %b want %b", k, x1_out, x1_seq[k-D+1]); end
          checks++; if (x2_out !== y2_seq[k-D+1]) begin failures++; $display("FAIL gap_x2_hold step %0d: got %b want %b", k, x2_out, y2_seq[k-D+1]); end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single_error;
    pulse_res();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 1'b0, (k == 5), 1'b0);
      checks++; if (out_valid !== (k >= D - 1)) begin failures++; $display("FAIL se_valid step %0d: got %b want %b", k, out_valid, (k >= D - 1)); end
      if (k >= D - 1) begin
        checks++; if (x1_out !== 1'b0) begin failures++; $display("FAIL se_x1 step %0d: got %b want 0", k, x1_out); end
      end
      checks++; if (best_pm !== ((k >= 6) ? 4'd1 : 4'd0)) begin failures++; $display("FAIL se_best_pm step %0d: got %0d want %0d", k, best_pm, (k >= 6) ? 1 : 0); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gaps;
    pulse_res();
    test_error_free(1'b1);
  endtask

  task automatic test_sync_clr;
    logic y1, y0;
    pulse_res();
    enc_s = 2'b00;
    for (int k = 0; k < 6; k++) begin
      encode(x1_seq[k], y1, y0);
      drive(1'b1, 1'b0, y2_seq[k], y1, y0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid: got %b want 0", out_valid); end
    checks++; if (best_pm !== 4'd0) begin failures++; $display("FAIL clr_best_pm: got %0d want 0", best_pm); end
    test_error_free(1'b0);
  endtask

  task automatic test_async_reset;
    logic y1, y0;
    pulse_res();
    enc_s = 2'b00;
    for (int k = 0; k < 14; k++) begin
      encode(x1_seq[k], y1, y0);
      drive(1'b1, 1'b0, y2_seq[k], y1, y0);
    end
    in_valid = 1'b0;
    checks++; if ((out_valid !== 1'b1) || (x1_out !== 1'b1)) begin failures++; $display("FAIL ares_pre: got valid=%b x1=%b want valid=1 x1=1", out_valid, x1_out); end
    #3 res = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ares_valid: got %b want 0", out_valid); end
    checks++; if (x1_out !== 1'b0) begin failures++; $display("FAIL ares_x1: got %b want 0", x1_out); end
    @(posedge clk);
    #2 res = 1'b0;
    @(posedge clk);
    #1;
    test_error_free(1'b0);
  endtask

  task automatic test_saturation;
    bit ev, ex2, ex1;
    int eb, mn;
    bit y2, ysym;
    pulse_res();
    model_reset();
    for (int k = 0; k < 40; k++) begin
      ysym = (k % 2 == 0);
      y2   = (k % 3 == 0);
      model_step(y2, ysym, ysym, ev, ex2, ex1, eb);
      drive(1'b1, 1'b0, y2, ysym, ysym);
      checks++; if (out_valid !== ev) begin failures++; $display("FAIL sat_valid step %0d: got %b want %b", k, out_valid, ev); end
      checks++; if (int'(best_pm) !== eb) begin failures++; $display("FAIL sat_best_pm step %0d: got %0d want %0d", k, best_pm, eb); end
      if (ev) begin
        checks++; if (x1_out !== ex1) begin failures++; $display("FAIL sat_x1 step %0d: got %b want %b", k, x1_out, ex1); end
        checks++; if (x2_out !== ex2) begin failures++; $display("FAIL sat_x2 step %0d: got %b want %b", k, x2_out, ex2); end
      end
      mn = int'(dut.pm_q[0]);
      if (int'(dut.pm_q[1]) < mn) mn = int'(dut.pm_q[1]);
      if (int'(dut.pm_q[2]) < mn) mn = int'(dut.pm_q[2]);
      if (int'(dut.pm_q[3]) < mn) mn = int'(dut.pm_q[3]);
      checks++; if (mn !== 0) begin failures++; $display("FAIL sat_min_pm step %0d: got %0d want 0", k, mn); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_tie_rule;
    bit ev, ex2, ex1;
    int eb;
    logic [1:0] sym;
    pulse_res();
    model_reset();
    for (int k = 0; k < 24; k++) begin
      sym = tie_syms[k];
      model_step(bit'(k % 2), sym[1], sym[0], ev, ex2, ex1, eb);
      drive(1'b1, 1'b0, logic'(k % 2), sym[1], sym[0]);
      checks++; if (out_valid !== ev) begin failures++; $display("FAIL tie_valid step %0d: got %b want %b", k, out_valid, ev); end
      checks++; if (int'(best_pm) !== eb) begin failures++; $display("FAIL tie_best_pm step %0d: got %0d want %0d", k, best_pm, eb); end
      if (ev) begin
        checks++; if (x1_out !== ex1) begin failures++; $display("FAIL tie_x1 step %0d: got %b want %b", k, x1_out, ex1); end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_error_free(1'b0);
    test_single_error();
    test_gaps();
    test_sync_clr();
    test_async_reset();
    test_saturation();
    test_tie_rule();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
